// File: rtl/pbit_group_scheduler.sv
// Graph-coloured Gibbs sweep sequencer: walks the group codes, freezes the network
// after each sweep for a valid/ready snapshot handoff, and counts sweeps to done.
module pbit_group_scheduler #(
    parameter int         NUM_GROUPS = 5,
    parameter int         DWELL_W    = 8,
    parameter int         SWEEP_W    = 16,
    parameter logic [2:0] IDLE_CODE  = 3'b111
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [SWEEP_W-1:0] num_sweeps,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic               skip_last,
    output logic [2:0]         group_EN,
    output logic               group_active,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic [SWEEP_W-1:0] sweep_count,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, SAMPLE, DONE} state_t;

    localparam logic [2:0] LAST_FULL = 3'(NUM_GROUPS - 1);
    localparam logic [2:0] LAST_SKIP = (NUM_GROUPS > 1) ? 3'(NUM_GROUPS - 2) : 3'd0;

    state_t             state, state_nx;
    logic [2:0]         g, g_nx;
    logic [DWELL_W-1:0] d, d_nx;
    logic [DWELL_W-1:0] cfg_dwell, cfg_dwell_nx;
    logic [SWEEP_W-1:0] cfg_sweeps, cfg_sweeps_nx;
    logic [2:0]         cfg_last, cfg_last_nx;
    logic [2:0]         group_en_nx;
    logic               active_nx, valid_nx, busy_nx, done_nx;
    logic [SWEEP_W-1:0] count_nx;

    // NOTE: every output is a flop; the combinational block only computes next values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            g            <= '0;
            d            <= '0;
            cfg_dwell    <= '0;
            cfg_sweeps   <= '0;
            cfg_last     <= '0;
            group_EN     <= IDLE_CODE;
            group_active <= 1'b0;
            sample_valid <= 1'b0;
            sweep_count  <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nx;
            g            <= g_nx;
            d            <= d_nx;
            cfg_dwell    <= cfg_dwell_nx;
            cfg_sweeps   <= cfg_sweeps_nx;
            cfg_last     <= cfg_last_nx;
            group_EN     <= group_en_nx;
            group_active <= active_nx;
            sample_valid <= valid_nx;
            sweep_count  <= count_nx;
            busy         <= busy_nx;
            done         <= done_nx;
        end
    end

    always_comb begin
        // NOTE: hold-current defaults on every signal keep this block latch-free.
        state_nx      = state;
        g_nx          = g;
        d_nx          = d;
        cfg_dwell_nx  = cfg_dwell;
        cfg_sweeps_nx = cfg_sweeps;
        cfg_last_nx   = cfg_last;
        group_en_nx   = group_EN;
        active_nx     = group_active;
        valid_nx      = sample_valid;
        count_nx      = sweep_count;
        busy_nx       = busy;
        done_nx       = done;

        if (abort) begin
            state_nx    = IDLE;
            g_nx        = '0;
            d_nx        = '0;
            group_en_nx = IDLE_CODE;
            active_nx   = 1'b0;
            valid_nx    = 1'b0;
            busy_nx     = 1'b0;
            done_nx     = 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Zero dwell or sweep count would stall or never finish; clamp to 1.
                        cfg_dwell_nx  = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
                        cfg_sweeps_nx = (num_sweeps == '0) ? SWEEP_W'(1) : num_sweeps;
                        cfg_last_nx   = skip_last ? LAST_SKIP : LAST_FULL;
                        count_nx      = '0;
                        g_nx          = '0;
                        d_nx          = '0;
                        state_nx      = RUN;
                        group_en_nx   = 3'd0;
                        active_nx     = 1'b1;
                        busy_nx       = 1'b1;
                        done_nx       = 1'b0;
                    end
                end
                RUN: begin
                    if (d == cfg_dwell - DWELL_W'(1)) begin
                        d_nx = '0;
                        if (g < cfg_last) begin
                            g_nx        = g + 3'd1;
                            group_en_nx = g + 3'd1;
                        end else begin
                            count_nx    = sweep_count + SWEEP_W'(1);
                            group_en_nx = IDLE_CODE;
                            active_nx   = 1'b0;
                            valid_nx    = 1'b1;
                            state_nx    = SAMPLE;
                        end
                    end else begin
                        d_nx = d + DWELL_W'(1);
                    end
                end
                SAMPLE: begin
                    if (sample_valid && sample_ready) begin
                        valid_nx = 1'b0;
                        if (sweep_count == cfg_sweeps) begin
                            state_nx = DONE;
                            done_nx  = 1'b1;
                            busy_nx  = 1'b0;
                        end else begin
                            state_nx    = RUN;
                            g_nx        = '0;
                            d_nx        = '0;
                            group_en_nx = 3'd0;
                            active_nx   = 1'b1;
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pbit_group_scheduler.sv
// Randomized bench for pbit_group_scheduler; expected per-cycle outputs come from
// nested sweep/group/dwell loops driven by the configuration and chosen stall lengths.
module tb_pbit_group_scheduler;

    localparam int         NG     = 5;
    localparam int         DW     = 8;
    localparam int         SW     = 16;
    localparam logic [2:0] IDLE_C = 3'b111;

    logic          clk = 1'b0;
    logic          rst, start, abort, skip_last, sample_ready;
    logic [SW-1:0] num_sweeps;
    logic [DW-1:0] dwell_cycles;
    logic [2:0]    group_EN;
    logic          group_active, sample_valid, busy, done;
    logic [SW-1:0] sweep_count;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pbit_group_scheduler #(
        .NUM_GROUPS(NG), .DWELL_W(DW), .SWEEP_W(SW), .IDLE_CODE(IDLE_C)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .num_sweeps(num_sweeps), .dwell_cycles(dwell_cycles), .skip_last(skip_last),
        .group_EN(group_EN), .group_active(group_active), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .sweep_count(sweep_count), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outputs(input string tag, input logic [2:0] en, input logic act,
                                 input logic val, input int cnt, input logic bsy, input logic dn);
        check({tag, ".group_EN"}, 32'(group_EN), 32'(en));
        check({tag, ".group_active"}, 32'(group_active), 32'(act));
        check({tag, ".sample_valid"}, 32'(sample_valid), 32'(val));
        check({tag, ".sweep_count"}, 32'(sweep_count), cnt);
        check({tag, ".busy"}, 32'(busy), 32'(bsy));
        check({tag, ".done"}, 32'(done), 32'(dn));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Random noise on inputs that must have no effect while a run is in progress.
    task automatic disturb();
        start        = 1'($urandom_range(0, 1));
        sample_ready = 1'($urandom_range(0, 1));
        num_sweeps   = SW'($urandom);
        dwell_cycles = DW'($urandom);
        skip_last    = 1'($urandom_range(0, 1));
    endtask

    // One run from IDLE/DONE. stall0 < 0 picks a random first stall; abort_sweep < 0 means no abort.
    task automatic run(input int sweeps, input int dwell, input bit skip, input int stall0,
                       input int abort_sweep, input int abort_group);
        int sw_eff, dw_eff, n_grp, stall;
        sw_eff = (sweeps == 0) ? 1 : sweeps;
        dw_eff = (dwell == 0) ? 1 : dwell;
        n_grp  = (skip && NG > 1) ? NG - 1 : NG;

        num_sweeps   = SW'(sweeps);
        dwell_cycles = DW'(dwell);
        skip_last    = skip;
        abort        = 1'b0;
        start        = 1'b1;
        step();
        start = 1'b0;

        for (int s = 1; s <= sw_eff; s++) begin
            for (int g = 0; g < n_grp; g++) begin
                for (int k = 0; k < dw_eff; k++) begin
                    check_outputs("run", 3'(g), 1'b1, 1'b0, s - 1, 1'b1, 1'b0);
                    if (s == abort_sweep && g == abort_group && k == 0) begin
                        abort        = 1'b1;
                        start        = 1'b1;
                        sample_ready = 1'b1;
                        step();
                        abort = 1'b0;
                        start = 1'b0;
                        check_outputs("abort", IDLE_C, 1'b0, 1'b0, s - 1, 1'b0, 1'b0);
                        step();
                        check_outputs("post_abort", IDLE_C, 1'b0, 1'b0, s - 1, 1'b0, 1'b0);
                        return;
                    end
                    disturb();
                    step();
                end
            end
            stall = (s == 1 && stall0 >= 0) ? stall0 : $urandom_range(0, 2);
            for (int i = 0; i < stall; i++) begin
                check_outputs("stall", IDLE_C, 1'b0, 1'b1, s, 1'b1, 1'b0);
                disturb();
                sample_ready = 1'b0;
                step();
            end
            check_outputs("sample", IDLE_C, 1'b0, 1'b1, s, 1'b1, 1'b0);
            disturb();
            sample_ready = 1'b1;
            step();
        end
        start = 1'b0;
        check_outputs("done", IDLE_C, 1'b0, 1'b0, sw_eff, 1'b0, 1'b1);
        step();
        check_outputs("done_hold", IDLE_C, 1'b0, 1'b0, sw_eff, 1'b0, 1'b1);
    endtask

    initial begin
        int lat;
        rst          = 1'b1;
        start        = 1'b0;
        abort        = 1'b0;
        skip_last    = 1'b0;
        sample_ready = 1'b1;
        num_sweeps   = '0;
        dwell_cycles = '0;
        step();
        step();
        check_outputs("reset", IDLE_C, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check_outputs("idle_after_reset", IDLE_C, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Basic run, every cycle checked.
        run(2, 2, 1'b0, 0, -1, -1);

        // Start-to-done latency with sample_ready tied high: 2 * (5*2 + 1).
        num_sweeps   = SW'(2);
        dwell_cycles = DW'(2);
        skip_last    = 1'b0;
        sample_ready = 1'b1;
        start        = 1'b1;
        step();
        start = 1'b0;
        lat   = 0;
        while (!done && lat < 200) begin
            step();
            lat++;
        end
        check("done_latency", 32'(lat), 32'(2 * (NG * 2 + 1)));

        run(1, 0, 1'b1, 0, -1, -1);        // skip_last, zero dwell
        run(2, 3, 1'b0, 10, -1, -1);       // 10-cycle backpressure after sweep 1
        run(0, 1, 1'b0, -1, -1, -1);       // zero sweeps treated as one
        run(4, 2, 1'b0, -1, 3, 2);         // abort+start in group 2 of sweep 3
        run(1, 2, 1'b0, 0, -1, -1);        // clean restart after abort

        for (int r = 0; r < 8; r++)
            run($urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)), -1, -1, -1);

        // Asynchronous reset between edges while running.
        num_sweeps   = SW'(3);
        dwell_cycles = DW'(3);
        skip_last    = 1'b0;
        start        = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("pre_reset.group_EN", 32'(group_EN), 32'(0));
        #2 rst = 1'b1;
        #1;
        check_outputs("async_reset", IDLE_C, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_outputs("idle_hold", IDLE_C, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
